localbus_ctrl: RTL

//  Parametrised local-bus controller: decodes one master access onto NSLV slave windows.

---
 rtl/localbus_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/localbus_ctrl.sv
// Local-bus controller: decodes one master access onto NSLV slave windows,
// with per-slave ready handshake, timeout watchdog and sticky fault capture.
module localbus_ctrl #(
  parameter int                     XLEN      = 32,
  parameter int                     NSLV      = 4,
  parameter logic [XLEN-1:0]        BASE_MASK = 32'hFFFF_0000,
  parameter logic [NSLV*XLEN-1:0]   BASE_TBL  = '0,
  parameter int                     TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      qin,
  input  logic [2:0]           we,
  output logic [XLEN-1:0]      qout,
  output logic                 ready,
  output logic                 err,
  output logic                 busy,
  output logic [NSLV-1:0]      s_sel,
  output logic [XLEN-1:0]      s_addr,
  output logic [XLEN-1:0]      s_qin,
  output logic [2:0]           s_we,
  input  logic [NSLV*XLEN-1:0] s_qout,
  input  logic [NSLV-1:0]      s_ready,
  output logic                 fault_vld,
  output logic [XLEN-1:0]      fault_addr,
  input  logic                 fault_clr
);

  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [XLEN-1:0]     r_qout, w_qout_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;
  logic [NSLV-1:0]     r_sel, w_sel_nxt;
  logic [XLEN-1:0]     r_addr, w_addr_nxt;
  logic [XLEN-1:0]     r_qin, w_qin_nxt;
  logic [2:0]          r_we, w_we_nxt;
  logic [IDXW-1:0]     r_idx, w_idx_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic                r_fault_vld, w_fault_vld_nxt;
  logic [XLEN-1:0]     r_fault_addr, w_fault_addr_nxt;

  logic [NSLV-1:0]     w_match;
  logic                w_hit;
  logic [IDXW-1:0]     w_hit_idx;
  logic                w_sel_ready;
  logic [XLEN-1:0]     w_sel_data;

  for (genvar g = 0; g < NSLV; g++) begin : g_match
    assign w_match[g] = ((addr & BASE_MASK) == BASE_TBL[g*XLEN +: XLEN]);
  end

  // Priority decode: scanning downwards lets the lowest matching window win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      w_hit     = w_match[i] ? 1'b1 : w_hit;
      w_hit_idx = w_match[i] ? IDXW'(i) : w_hit_idx;
    end
  end

  assign w_sel_ready = s_ready[r_idx];
  assign w_sel_data  = s_qout[r_idx*XLEN +: XLEN];

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_qout_nxt       = r_qout;
    w_ready_nxt      = 1'b0;
    w_err_nxt        = 1'b0;
    w_sel_nxt        = r_sel;
    w_addr_nxt       = r_addr;
    w_qin_nxt        = r_qin;
    w_we_nxt         = r_we;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_fault_vld_nxt  = fault_clr ? 1'b0 : r_fault_vld;
    w_fault_addr_nxt = r_fault_addr;
    case (r_state)
      ST_IDLE: begin
        if (req && w_hit) begin
          w_state_nxt = ST_ACCESS;
          w_addr_nxt  = addr;
          w_qin_nxt   = qin;
          w_we_nxt    = we;
          w_idx_nxt   = w_hit_idx;
          w_sel_nxt   = NSLV'(1'b1) << w_hit_idx;
          w_cnt_nxt   = 8'd0;
        end else if (req) begin
          // Unmapped: the error response is raised on this edge so ready lands at T1.
          w_state_nxt      = ST_ERR;
          w_ready_nxt      = 1'b1;
          w_err_nxt        = 1'b1;
          w_qout_nxt       = '0;
          w_fault_vld_nxt  = 1'b1;
          w_fault_addr_nxt = addr;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
          w_qout_nxt  = (r_we != 3'b000) ? '0 : w_sel_data;
          w_sel_nxt   = '0;
          w_we_nxt    = 3'b000;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_state_nxt      = ST_ERR;
          w_ready_nxt      = 1'b1;
          w_err_nxt        = 1'b1;
          w_qout_nxt       = '0;
          w_sel_nxt        = '0;
          w_we_nxt         = 3'b000;
          w_fault_vld_nxt  = 1'b1;
          w_fault_addr_nxt = r_addr;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
        w_we_nxt    = 3'b000;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, latched access fields and fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qout       <= '0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_sel        <= '0;
      r_addr       <= '0;
      r_qin        <= '0;
      r_we         <= 3'b000;
      r_idx        <= '0;
      r_cnt        <= 8'd0;
      r_fault_vld  <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_qout       <= w_qout_nxt;
      r_ready      <= w_ready_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
      r_sel        <= w_sel_nxt;
      r_addr       <= w_addr_nxt;
      r_qin        <= w_qin_nxt;
      r_we         <= w_we_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fault_vld  <= w_fault_vld_nxt;
      r_fault_addr <= w_fault_addr_nxt;
    end
  end

  assign qout       = r_qout;
  assign ready      = r_ready;
  assign err        = r_err;
  assign busy       = r_busy;
  assign s_sel      = r_sel;
  assign s_addr     = r_addr;
  assign s_qin      = r_qin;
  assign s_we       = r_we;
  assign fault_vld  = r_fault_vld;
  assign fault_addr = r_fault_addr;

endmodule
